// File: rtl/axi4_arbiter_2to1.sv
// Two-master, one-slave AXI4 arbiter: whole transactions granted round-robin,
// one outstanding at a time, all channels passed through combinationally.
module axi4_arbiter_2to1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  // master 0 (instruction fetch)
  input  logic                m0_awvalid,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic [ID_W-1:0]     m0_awid,
  input  logic [7:0]          m0_awlen,
  input  logic [2:0]          m0_awsize,
  input  logic [1:0]          m0_awburst,
  output logic                m0_awready,
  input  logic                m0_wvalid,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wlast,
  output logic                m0_wready,
  output logic                m0_bvalid,
  output logic [1:0]          m0_bresp,
  output logic [ID_W-1:0]     m0_bid,
  input  logic                m0_bready,
  input  logic                m0_arvalid,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_arready,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rlast,
  output logic [ID_W-1:0]     m0_rid,
  input  logic                m0_rready,
  // master 1 (load/store)
  input  logic                m1_awvalid,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  output logic                m1_awready,
  input  logic                m1_wvalid,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  output logic                m1_wready,
  output logic                m1_bvalid,
  output logic [1:0]          m1_bresp,
  output logic [ID_W-1:0]     m1_bid,
  input  logic                m1_bready,
  input  logic                m1_arvalid,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_arready,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rlast,
  output logic [ID_W-1:0]     m1_rid,
  input  logic                m1_rready,
  // slave side (pmem)
  output logic                s_awvalid,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  input  logic                s_awready,
  output logic                s_wvalid,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  input  logic                s_wready,
  input  logic                s_bvalid,
  input  logic [1:0]          s_bresp,
  input  logic [ID_W-1:0]     s_bid,
  output logic                s_bready,
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_arready,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rlast,
  input  logic [ID_W-1:0]     s_rid,
  output logic                s_rready
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t state;
  logic   gnt;
  logic   prio;

  logic req0, req1, pick, pick_wr;
  logic rd_act, wr_act;
  logic m0_rd, m1_rd, m0_wr, m1_wr;

  // A master asserting both AW and AR is treated as a write request
  assign req0    = m0_awvalid | m0_arvalid;
  assign req1    = m1_awvalid | m1_arvalid;
  assign pick    = (req0 & req1) ? prio : req1;
  assign pick_wr = pick ? m1_awvalid : m0_awvalid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            gnt   <= pick;
            state <= pick_wr ? WR : RD;
          end
        end
        RD: begin
          if (s_rvalid & s_rready & s_rlast) begin
            state <= IDLE;
            prio  <= ~gnt;
          end
        end
        WR: begin
          if (s_bvalid & s_bready) begin
            state <= IDLE;
            prio  <= ~gnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_act = (state == RD);
  assign wr_act = (state == WR);
  assign m0_rd  = rd_act & ~gnt;
  assign m1_rd  = rd_act &  gnt;
  assign m0_wr  = wr_act & ~gnt;
  assign m1_wr  = wr_act &  gnt;

  // Slave-side request channels: routed from the granted master, else zero
  assign s_awvalid = m0_wr ? m0_awvalid : (m1_wr ? m1_awvalid : 1'b0);
  assign s_awaddr  = m0_wr ? m0_awaddr  : (m1_wr ? m1_awaddr  : '0);
  assign s_awid    = m0_wr ? m0_awid    : (m1_wr ? m1_awid    : '0);
  assign s_awlen   = m0_wr ? m0_awlen   : (m1_wr ? m1_awlen   : '0);
  assign s_awsize  = m0_wr ? m0_awsize  : (m1_wr ? m1_awsize  : '0);
  assign s_awburst = m0_wr ? m0_awburst : (m1_wr ? m1_awburst : '0);
  assign s_wvalid  = m0_wr ? m0_wvalid  : (m1_wr ? m1_wvalid  : 1'b0);
  assign s_wdata   = m0_wr ? m0_wdata   : (m1_wr ? m1_wdata   : '0);
  assign s_wstrb   = m0_wr ? m0_wstrb   : (m1_wr ? m1_wstrb   : '0);
  assign s_wlast   = m0_wr ? m0_wlast   : (m1_wr ? m1_wlast   : 1'b0);
  assign s_bready  = m0_wr ? m0_bready  : (m1_wr ? m1_bready  : 1'b0);
  assign s_arvalid = m0_rd ? m0_arvalid : (m1_rd ? m1_arvalid : 1'b0);
  assign s_araddr  = m0_rd ? m0_araddr  : (m1_rd ? m1_araddr  : '0);
  assign s_arid    = m0_rd ? m0_arid    : (m1_rd ? m1_arid    : '0);
  assign s_arlen   = m0_rd ? m0_arlen   : (m1_rd ? m1_arlen   : '0);
  assign s_arsize  = m0_rd ? m0_arsize  : (m1_rd ? m1_arsize  : '0);
  assign s_arburst = m0_rd ? m0_arburst : (m1_rd ? m1_arburst : '0);
  assign s_rready  = m0_rd ? m0_rready  : (m1_rd ? m1_rready  : 1'b0);

  // Master-side responses: only the granted master sees anything non-zero
  assign m0_awready = m0_wr & s_awready;
  assign m0_wready  = m0_wr & s_wready;
  assign m0_bvalid  = m0_wr & s_bvalid;
  assign m0_bresp   = m0_wr ? s_bresp : '0;
  assign m0_bid     = m0_wr ? s_bid   : '0;
  assign m0_arready = m0_rd & s_arready;
  assign m0_rvalid  = m0_rd & s_rvalid;
  assign m0_rdata   = m0_rd ? s_rdata : '0;
  assign m0_rresp   = m0_rd ? s_rresp : '0;
  assign m0_rlast   = m0_rd & s_rlast;
  assign m0_rid     = m0_rd ? s_rid   : '0;

  assign m1_awready = m1_wr & s_awready;
  assign m1_wready  = m1_wr & s_wready;
  assign m1_bvalid  = m1_wr & s_bvalid;
  assign m1_bresp   = m1_wr ? s_bresp : '0;
  assign m1_bid     = m1_wr ? s_bid   : '0;
  assign m1_arready = m1_rd & s_arready;
  assign m1_rvalid  = m1_rd & s_rvalid;
  assign m1_rdata   = m1_rd ? s_rdata : '0;
  assign m1_rresp   = m1_rd ? s_rresp : '0;
  assign m1_rlast   = m1_rd & s_rlast;
  assign m1_rid     = m1_rd ? s_rid   : '0;

endmodule

// File: tb/tb_axi4_arbiter_2to1.sv
// Directed bench for axi4_arbiter_2to1: the bench plays both masters and pmem.
module tb_axi4_arbiter_2to1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wlast, m0_wready, m0_bvalid, m0_bready;
  logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
  logic [3:0]  m0_awid, m0_wstrb, m0_bid, m0_arid, m0_rid;
  logic [7:0]  m0_awlen, m0_arlen;
  logic [2:0]  m0_awsize, m0_arsize;
  logic [1:0]  m0_awburst, m0_bresp, m0_arburst, m0_rresp;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;

  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
  logic [3:0]  m1_awid, m1_wstrb, m1_bid, m1_arid, m1_rid;
  logic [7:0]  m1_awlen, m1_arlen;
  logic [2:0]  m1_awsize, m1_arsize;
  logic [1:0]  m1_awburst, m1_bresp, m1_arburst, m1_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;

  logic        s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_awid, s_wstrb, s_bid, s_arid, s_rid;
  logic [7:0]  s_awlen, s_arlen;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_bresp, s_arburst, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;

  int errors = 0;
  int checks = 0;

  axi4_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awid(m0_awid), .m0_awlen(m0_awlen),
    .m0_awsize(m0_awsize), .m0_awburst(m0_awburst), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast),
    .m0_wready(m0_wready), .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bid(m0_bid),
    .m0_bready(m0_bready), .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rid(m0_rid), .m0_rready(m0_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
    .m1_bready(m1_bready), .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rid(m1_rid), .m1_rready(m1_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_bready(s_bready), .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Entered during an IDLE cycle with master g requesting a single-beat read;
  // returns in the IDLE cycle that follows the completing R beat.
  task automatic rd_txn(input bit g, input bit drop);
    s_arready = 1'b1;
    #1;
    chk("idle_s_arvalid", s_arvalid, 1'b0);
    chk("idle_m0_arready", m0_arready, 1'b0);
    chk("idle_m1_arready", m1_arready, 1'b0);
    tick();
    #1;
    chk("gnt_arready", g ? m1_arready : m0_arready, 1'b1);
    chk("nongnt_arready", g ? m0_arready : m1_arready, 1'b0);
    chk("gnt_s_araddr", s_araddr, g ? 32'h8000_0100 : 32'h8000_0000);
    tick();
    s_arready = 1'b0;
    if (drop) begin
      if (g) m1_arvalid = 1'b0;
      else   m0_arvalid = 1'b0;
    end
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    s_rdata  = g ? 32'hA000_0001 : 32'hA000_0000;
    s_rid    = g ? 4'd3 : 4'd2;
    #1;
    chk("gnt_rvalid", g ? m1_rvalid : m0_rvalid, 1'b1);
    chk("nongnt_rvalid", g ? m0_rvalid : m1_rvalid, 1'b0);
    chk("gnt_rdata", g ? m1_rdata : m0_rdata, g ? 32'hA000_0001 : 32'hA000_0000);
    chk("gnt_rid", g ? m1_rid : m0_rid, g ? 4'd3 : 4'd2);
    tick();
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  initial begin
    {m0_awvalid, m0_awaddr, m0_awid, m0_awlen, m0_awsize, m0_awburst} = '0;
    {m0_wvalid, m0_wdata, m0_wstrb, m0_wlast, m0_arvalid, m0_araddr, m0_arid} = '0;
    {m0_arlen, m0_arsize, m0_arburst} = '0;
    {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = '0;
    {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast, m1_arvalid, m1_araddr, m1_arid} = '0;
    {m1_arlen, m1_arsize, m1_arburst} = '0;
    {s_awready, s_wready, s_bvalid, s_bresp, s_bid, s_arready} = '0;
    {s_rvalid, s_rdata, s_rresp, s_rlast, s_rid} = '0;
    m0_bready = 1'b1; m1_bready = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
    m0_araddr = 32'h8000_0000; m1_araddr = 32'h8000_0100;
    m0_arsize = 3'd2; m1_arsize = 3'd2; m0_arburst = 2'd1; m1_arburst = 2'd1;

    // Reset state: requests and pmem activity present, outputs must stay 0
    #3 reset = 1'b1;
    m0_arvalid = 1'b1; s_arready = 1'b1; s_rvalid = 1'b1; s_bvalid = 1'b1;
    #1;
    chk("rst_s_arvalid", s_arvalid, 1'b0);
    chk("rst_s_araddr", s_araddr, 32'h0);
    chk("rst_m0_arready", m0_arready, 1'b0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m0_bvalid", m0_bvalid, 1'b0);
    chk("rst_s_rready", s_rready, 1'b0);
    tick();
    tick();
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b0; s_bvalid = 1'b0;
    reset = 1'b0;

    // Single 4-beat read from m0
    tick();
    m0_arvalid = 1'b1; m0_arlen = 8'd3; m0_arid = 4'd1; s_arready = 1'b1;
    #1;
    chk("t1_idle_s_arvalid", s_arvalid, 1'b0);
    tick();
    #1;
    chk("t1_s_arvalid", s_arvalid, 1'b1);
    chk("t1_s_araddr", s_araddr, 32'h8000_0000);
    chk("t1_s_arlen", s_arlen, 8'd3);
    chk("t1_s_arid", s_arid, 4'd1);
    chk("t1_m0_arready", m0_arready, 1'b1);
    chk("t1_s_awvalid", s_awvalid, 1'b0);
    tick();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      s_rvalid = 1'b1; s_rdata = 32'h1000 + b; s_rid = 4'd1; s_rlast = (b == 3);
      #1;
      chk("t1_m0_rvalid", m0_rvalid, 1'b1);
      chk("t1_m0_rdata", m0_rdata, 32'h1000 + b);
      chk("t1_m0_rid", m0_rid, 4'd1);
      chk("t1_m0_rlast", m0_rlast, (b == 3));
      chk("t1_m1_rvalid", m1_rvalid, 1'b0);
      tick();
    end
    #1;
    chk("t1_idle_after", m0_rvalid, 1'b0);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    m0_arlen = 8'd0;

    // Simultaneous single-beat reads straight after a reset: m0 first
    reset = 1'b1;
    #1 reset = 1'b0;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    rd_txn(1'b0, 1'b1);
    rd_txn(1'b1, 1'b1);

    // Contention: both hold arvalid, grants must alternate m0, m1, m0
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    rd_txn(1'b0, 1'b0);
    rd_txn(1'b1, 1'b0);
    rd_txn(1'b0, 1'b0);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    // m1 write with W presented before AW; m1 also holds AR
    m1_wvalid = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wlast = 1'b1;
    s_wready = 1'b1;
    #1;
    chk("t4_idle_s_wvalid", s_wvalid, 1'b0);
    chk("t4_idle_m1_wready", m1_wready, 1'b0);
    tick();
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_0010; m1_awid = 4'd5; m1_arvalid = 1'b1;
    s_awready = 1'b0; s_arready = 1'b1;
    #1;
    chk("t4_idle_s_awvalid", s_awvalid, 1'b0);
    tick();
    #1;
    chk("t4_s_wvalid", s_wvalid, 1'b1);
    chk("t4_s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("t4_s_wstrb", s_wstrb, 4'hF);
    chk("t4_m1_wready", m1_wready, 1'b1);
    chk("t4_s_awvalid", s_awvalid, 1'b1);
    chk("t4_m1_awready_early", m1_awready, 1'b0);
    chk("t4_m1_arready_a", m1_arready, 1'b0);
    chk("t4_s_arvalid", s_arvalid, 1'b0);
    tick();
    m1_wvalid = 1'b0; s_awready = 1'b1;
    #1;
    chk("t4_m1_awready", m1_awready, 1'b1);
    chk("t4_s_awaddr", s_awaddr, 32'h8000_0010);
    chk("t4_s_awid", s_awid, 4'd5);
    tick();
    m1_awvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'd0; s_bid = 4'd5;
    #1;
    chk("t4_m1_bvalid", m1_bvalid, 1'b1);
    chk("t4_m1_bresp", m1_bresp, 2'd0);
    chk("t4_m1_bid", m1_bid, 4'd5);
    chk("t4_s_bready", s_bready, 1'b1);
    chk("t4_m0_bvalid", m0_bvalid, 1'b0);
    chk("t4_m1_arready_b", m1_arready, 1'b0);
    tick();
    s_bvalid = 1'b0;
    rd_txn(1'b1, 1'b1);

    // m0 asserts AW and AR together: write first, SLVERR forwarded, then read
    m0_awvalid = 1'b1; m0_awaddr = 32'h8000_0020; m0_awid = 4'd6; m0_arvalid = 1'b1;
    m0_wvalid = 1'b1; m0_wdata = 32'h1234_5678; m0_wstrb = 4'hF; m0_wlast = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    #1;
    chk("t5_idle_s_awvalid", s_awvalid, 1'b0);
    tick();
    #1;
    chk("t5_s_awvalid", s_awvalid, 1'b1);
    chk("t5_m0_awready", m0_awready, 1'b1);
    chk("t5_s_wdata", s_wdata, 32'h1234_5678);
    chk("t5_m0_arready", m0_arready, 1'b0);
    chk("t5_s_arvalid", s_arvalid, 1'b0);
    tick();
    m0_awvalid = 1'b0; m0_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'd2; s_bid = 4'd6;
    #1;
    chk("t5_m0_bvalid", m0_bvalid, 1'b1);
    chk("t5_m0_bresp", m0_bresp, 2'd2);
    tick();
    s_bvalid = 1'b0; s_bresp = 2'd0;
    rd_txn(1'b0, 1'b1);

    // Reset asserted during beat 2 of a 4-beat m0 read
    m0_arvalid = 1'b1; m0_arlen = 8'd3; s_arready = 1'b1;
    tick();
    tick();
    m0_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h2000; s_rlast = 1'b0;
    tick();
    s_rdata = 32'h2001;
    #1;
    chk("t6_beat2_m0_rvalid", m0_rvalid, 1'b1);
    reset = 1'b1;
    #1;
    chk("t6_rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("t6_rst_m0_rdata", m0_rdata, 32'h0);
    chk("t6_rst_s_rready", s_rready, 1'b0);
    chk("t6_rst_m0_arready", m0_arready, 1'b0);
    tick();
    s_rvalid = 1'b0; s_rdata = 32'h0; m0_arlen = 8'd0;
    reset = 1'b0;
    // Both request: m0 must win again because the pointer was reset
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    rd_txn(1'b0, 1'b1);
    rd_txn(1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
